// File: rtl/sniff_fifo_decoder_pkg.sv
// Shared definitions for the sniff FIFO entry format and its read-side decoder.
// Entry layout (18 bits): cmd [1:0], short delta [4:2], data [12:5], status [17:13];
// TIME entries reuse [17:2] as the full delta.
package sniff_fifo_decoder_pkg;

  localparam int FE_FIFO_ENTRY_W         = 18;

  localparam int FE_FIFO_CMD_START       = 0;
  localparam int FE_FIFO_CMD_BIT_LEN     = 2;
  localparam int FE_FIFO_SHORTTIME_START = 2;
  localparam int FE_FIFO_SHORTTIME_LEN   = 3;
  localparam int FE_FIFO_TIME_START      = FE_FIFO_SHORTTIME_START;
  localparam int FE_FIFO_TIME_LEN        = FE_FIFO_SHORTTIME_LEN;
  localparam int FE_FIFO_DATA_START      = 5;
  localparam int FE_FIFO_DATA_LEN        = 8;
  localparam int FE_FIFO_STATUS_START    = 13;
  localparam int FE_FIFO_STATUS_LEN      = 5;
  localparam int FE_FIFO_FULLTIME_START  = 2;
  localparam int FE_FIFO_FULLTIME_LEN    = 16;

  localparam logic [1:0] FE_FIFO_CMD_DATA = 2'd0;
  localparam logic [1:0] FE_FIFO_CMD_STAT = 2'd1;
  localparam logic [1:0] FE_FIFO_CMD_TIME = 2'd2;
  localparam logic [1:0] FE_FIFO_CMD_RSVD = 2'd3;

  typedef enum logic {
    DEC_RUN   = 1'b0,
    DEC_ERROR = 1'b1
  } dec_state_t;

endpackage

// File: rtl/sniff_fifo_decoder_if.sv
// FIFO read port and decoded-event stream of the sniff FIFO decoder.
// master = decoder side, slave = FIFO/consumer side.
// Optional O_ev_seq is present only when SNIFF_DECODER_SEQ_EN is defined.
interface sniff_fifo_decoder_if
  import sniff_fifo_decoder_pkg::*;
#(
  parameter int pTS_WIDTH = 32
);
  logic [FE_FIFO_ENTRY_W-1:0] I_fifo_dout;
  logic                       I_fifo_empty;
  logic                       O_fifo_rd_en;
  logic                       O_ev_valid;
  logic                       I_ev_ready;
  logic [pTS_WIDTH-1:0]       O_ev_time;
  logic [7:0]                 O_ev_data;
  logic [4:0]                 O_ev_stat;
  logic                       O_ev_is_data;
`ifdef SNIFF_DECODER_SEQ_EN
  logic [15:0]                O_ev_seq;
`endif

  modport master (
`ifdef SNIFF_DECODER_SEQ_EN
    output O_ev_seq,
`endif
    input  I_fifo_dout, I_fifo_empty, I_ev_ready,
    output O_fifo_rd_en, O_ev_valid, O_ev_time, O_ev_data, O_ev_stat, O_ev_is_data
  );

  modport slave (
`ifdef SNIFF_DECODER_SEQ_EN
    input  O_ev_seq,
`endif
    output I_fifo_dout, I_fifo_empty, I_ev_ready,
    input  O_fifo_rd_en, O_ev_valid, O_ev_time, O_ev_data, O_ev_stat, O_ev_is_data
  );

endinterface

// File: rtl/sniff_fifo_decoder.sv
// Read-side decoder for the sniff FIFO: pops FWFT entries, rebuilds the absolute
// timestamp from delta fields and emits one event per DATA/STAT entry.
// Optional macro SNIFF_DECODER_SEQ_EN adds a 16-bit per-event sequence number.
module sniff_fifo_decoder
  import sniff_fifo_decoder_pkg::*;
#(
  parameter int pTS_WIDTH        = 32,
  parameter int pFULLTIME_WIDTH  = 16,
  parameter int pSHORTTIME_WIDTH = 3
) (
  input  logic                 cwusb_clk,
  input  logic                 reset_n,
  input  logic                 I_clear,
  sniff_fifo_decoder_if.master bus,
  output logic                 O_error,
  output logic                 O_wrapped
);

  // Modulo add with the carry kept in the top bit so wrap can be flagged.
  function automatic logic [pTS_WIDTH:0] acc_add(input logic [pTS_WIDTH-1:0] a,
                                                 input logic [pTS_WIDTH-1:0] d);
    return {1'b0, a} + {1'b0, d};
  endfunction

  dec_state_t            state, state_next;
  logic [1:0]            cmd;
  logic [pTS_WIDTH-1:0]  delta;
  logic [pTS_WIDTH-1:0]  acc;
  logic [pTS_WIDTH:0]    sum;
  logic                  pop, emit, advance, is_data;

  logic                  vld_p1;
  logic [pTS_WIDTH-1:0]  ev_time_p1;
  logic [7:0]            ev_data_p1;
  logic [4:0]            ev_stat_p1;
  logic                  ev_is_data_p1;

  assign cmd     = bus.I_fifo_dout[FE_FIFO_CMD_START +: FE_FIFO_CMD_BIT_LEN];
  assign is_data = (cmd == FE_FIFO_CMD_DATA);

  // Popping is combinational so the FWFT head is consumed in the cycle it is used;
  // reset_n gates it so nothing is taken from the FIFO while held in reset.
  assign pop = reset_n && (state == DEC_RUN) && !bus.I_fifo_empty && !I_clear &&
               (!vld_p1 || bus.I_ev_ready);
  assign emit    = pop && (cmd == FE_FIFO_CMD_DATA || cmd == FE_FIFO_CMD_STAT);
  assign advance = pop && (cmd != FE_FIFO_CMD_RSVD);

  // Select the zero-extended delta: full field for TIME, short field otherwise.
  always_comb begin
    delta = '0;
    if (cmd == FE_FIFO_CMD_TIME)
      delta[pFULLTIME_WIDTH-1:0] = bus.I_fifo_dout[FE_FIFO_FULLTIME_START +: pFULLTIME_WIDTH];
    else
      delta[pSHORTTIME_WIDTH-1:0] = bus.I_fifo_dout[FE_FIFO_SHORTTIME_START +: pSHORTTIME_WIDTH];
  end

  assign sum = acc_add(acc, delta);

  // FSM state register.
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) state <= DEC_RUN;
    else          state <= state_next;
  end

  // FSM next state: reserved command traps into ERROR, only clear leaves it.
  always_comb begin
    state_next = state;
    if (I_clear)
      state_next = DEC_RUN;
    else if (pop && cmd == FE_FIFO_CMD_RSVD)
      state_next = DEC_ERROR;
  end

  // Timestamp accumulator and sticky wrap flag.
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      O_wrapped <= 1'b0;
    end else if (I_clear) begin
      acc       <= '0;
      O_wrapped <= 1'b0;
    end else if (advance) begin
      acc <= sum[pTS_WIDTH-1:0];
      if (sum[pTS_WIDTH]) O_wrapped <= 1'b1;
    end
  end

  // ---- stage p1: event output register, held while valid and not accepted ----
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1        <= 1'b0;
      ev_time_p1    <= '0;
      ev_data_p1    <= '0;
      ev_stat_p1    <= '0;
      ev_is_data_p1 <= 1'b0;
    end else if (I_clear) begin
      vld_p1 <= 1'b0;
    end else if (emit) begin
      vld_p1        <= 1'b1;
      ev_time_p1    <= sum[pTS_WIDTH-1:0];
      ev_data_p1    <= is_data ? bus.I_fifo_dout[FE_FIFO_DATA_START +: FE_FIFO_DATA_LEN] : 8'h00;
      ev_stat_p1    <= bus.I_fifo_dout[FE_FIFO_STATUS_START +: FE_FIFO_STATUS_LEN];
      ev_is_data_p1 <= is_data;
    end else if (bus.I_ev_ready) begin
      vld_p1 <= 1'b0;
    end
  end

`ifdef SNIFF_DECODER_SEQ_EN
  logic [15:0] seq_cnt;
  logic [15:0] ev_seq_p1;

  // Sequence number of each emitted event; TIME entries do not count.
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_cnt   <= '0;
      ev_seq_p1 <= '0;
    end else if (I_clear) begin
      seq_cnt   <= '0;
      ev_seq_p1 <= '0;
    end else if (emit) begin
      ev_seq_p1 <= seq_cnt;
      seq_cnt   <= seq_cnt + 16'd1;
    end
  end

  assign bus.O_ev_seq = ev_seq_p1;
`endif

  assign bus.O_fifo_rd_en = pop;
  assign bus.O_ev_valid   = vld_p1;
  assign bus.O_ev_time    = ev_time_p1;
  assign bus.O_ev_data    = ev_data_p1;
  assign bus.O_ev_stat    = ev_stat_p1;
  assign bus.O_ev_is_data = ev_is_data_p1;
  assign O_error          = (state == DEC_ERROR);

endmodule

// File: tb/tb_sniff_fifo_decoder.sv
// Directed bench for sniff_fifo_decoder with a small FWFT FIFO model in front.
module tb_sniff_fifo_decoder;
  import sniff_fifo_decoder_pkg::*;

  logic cwusb_clk = 1'b0;
  logic reset_n   = 1'b0;
  logic I_clear   = 1'b0;
  logic O_error, O_wrapped;

  always #5 cwusb_clk = ~cwusb_clk;

  sniff_fifo_decoder_if #(.pTS_WIDTH(32)) bus ();

  sniff_fifo_decoder #(
    .pTS_WIDTH(32), .pFULLTIME_WIDTH(16), .pSHORTTIME_WIDTH(3)
  ) dut (
    .cwusb_clk (cwusb_clk),
    .reset_n   (reset_n),
    .I_clear   (I_clear),
    .bus       (bus),
    .O_error   (O_error),
    .O_wrapped (O_wrapped)
  );

  // FWFT FIFO model
  logic [17:0] mem [0:127];
  int wp = 0;
  int rp = 0;
  int pops = 0;
  assign bus.I_fifo_dout  = mem[rp[6:0]];
  assign bus.I_fifo_empty = (wp == rp);

  always @(posedge cwusb_clk) begin
    if (bus.O_fifo_rd_en) begin
      rp   <= rp + 1;
      pops <= pops + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge cwusb_clk);
    #1;
  endtask

  task automatic push(input logic [17:0] e);
    mem[wp[6:0]] = e;
    wp = wp + 1;
  endtask

  function automatic logic [17:0] ent(input logic [1:0] c, input logic [2:0] t,
                                      input logic [7:0] d, input logic [4:0] s);
    return {s, d, t, c};
  endfunction

  function automatic logic [17:0] tent(input logic [15:0] dt);
    return {dt, 2'd2};
  endfunction

  task automatic do_clear();
    I_clear = 1'b1;
    step(1);
    I_clear = 1'b0;
  endtask

  int p0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    bus.I_ev_ready = 1'b0;

    // reset state
    step(2);
    chk("rst_valid", bus.O_ev_valid, 1'b0);
    chk("rst_rd_en", bus.O_fifo_rd_en, 1'b0);
    chk("rst_error", O_error, 1'b0);
    chk("rst_wrapped", O_wrapped, 1'b0);
    chk("rst_time", bus.O_ev_time, 32'h0);
    reset_n = 1'b1;
    step(1);

    // DATA then STAT, back to back
    do_clear();
    bus.I_ev_ready = 1'b1;
    push(ent(2'd0, 3'd3, 8'hA5, 5'h01));
    push(ent(2'd1, 3'd2, 8'hEE, 5'h10));
    step(1);
    chk("ev1_valid", bus.O_ev_valid, 1'b1);
    chk("ev1_time", bus.O_ev_time, 32'd3);
    chk("ev1_data", bus.O_ev_data, 8'hA5);
    chk("ev1_stat", bus.O_ev_stat, 5'h01);
    chk("ev1_isdata", bus.O_ev_is_data, 1'b1);
    step(1);
    chk("ev2_valid", bus.O_ev_valid, 1'b1);
    chk("ev2_time", bus.O_ev_time, 32'd5);
    chk("ev2_data", bus.O_ev_data, 8'h00);
    chk("ev2_stat", bus.O_ev_stat, 5'h10);
    chk("ev2_isdata", bus.O_ev_is_data, 1'b0);
    step(1);
    chk("ev2_drain", bus.O_ev_valid, 1'b0);

    // TIME then DATA
    do_clear();
    push(tent(16'h1000));
    push(ent(2'd0, 3'd1, 8'h42, 5'h00));
    step(1);
    chk("time_noev", bus.O_ev_valid, 1'b0);
    step(1);
    chk("td_valid", bus.O_ev_valid, 1'b1);
    chk("td_time", bus.O_ev_time, 32'h1001);
    chk("td_data", bus.O_ev_data, 8'h42);
    step(1);
    chk("td_drain", bus.O_ev_valid, 1'b0);

    // accumulator wrap: 65536 x 0xFFFF + 0xFFFE = 0xFFFFFFFE
    do_clear();
    for (int i = 0; i < 65536; i++) begin
      push(tent(16'hFFFF));
      step(1);
    end
    push(tent(16'hFFFE));
    step(1);
    chk("prewrap_flag", O_wrapped, 1'b0);
    chk("prewrap_noev", bus.O_ev_valid, 1'b0);
    push(ent(2'd0, 3'd3, 8'h77, 5'h00));
    step(1);
    chk("wrap_valid", bus.O_ev_valid, 1'b1);
    chk("wrap_time", bus.O_ev_time, 32'h1);
    chk("wrap_flag", O_wrapped, 1'b1);
    do_clear();
    chk("wrap_cleared", O_wrapped, 1'b0);
    chk("clear_valid", bus.O_ev_valid, 1'b0);

    // backpressure: 4 entries, ready low for 10 cycles
    bus.I_ev_ready = 1'b0;
    p0 = pops;
    push(ent(2'd0, 3'd1, 8'h11, 5'h00));
    push(ent(2'd0, 3'd2, 8'h22, 5'h00));
    push(ent(2'd0, 3'd3, 8'h33, 5'h00));
    push(ent(2'd0, 3'd1, 8'h44, 5'h00));
    step(1);
    chk("bp_first_time", bus.O_ev_time, 32'd1);
    step(9);
    chk("bp_pops", pops - p0, 1);
    chk("bp_valid", bus.O_ev_valid, 1'b1);
    chk("bp_hold_time", bus.O_ev_time, 32'd1);
    chk("bp_hold_data", bus.O_ev_data, 8'h11);
    bus.I_ev_ready = 1'b1;
    step(1);
    chk("bp_e2_time", bus.O_ev_time, 32'd3);
    chk("bp_e2_data", bus.O_ev_data, 8'h22);
    step(1);
    chk("bp_e3_time", bus.O_ev_time, 32'd6);
    chk("bp_e3_data", bus.O_ev_data, 8'h33);
    step(1);
    chk("bp_e4_valid", bus.O_ev_valid, 1'b1);
    chk("bp_e4_time", bus.O_ev_time, 32'd7);
    chk("bp_e4_data", bus.O_ev_data, 8'h44);
    step(1);
    chk("bp_drain", bus.O_ev_valid, 1'b0);
    chk("bp_total_pops", pops - p0, 4);

    // reserved command traps into ERROR
    do_clear();
    push(ent(2'd3, 3'd0, 8'h00, 5'h00));
    push(ent(2'd0, 3'd5, 8'h5A, 5'h00));
    step(1);
    chk("err_flag", O_error, 1'b1);
    chk("err_rd_en", bus.O_fifo_rd_en, 1'b0);
    chk("err_noev", bus.O_ev_valid, 1'b0);
    p0 = pops;
    step(3);
    chk("err_no_pops", pops - p0, 0);
    chk("err_head_kept", wp - rp, 1);
    I_clear = 1'b1;
    #1;
    chk("clr_blocks_pop", bus.O_fifo_rd_en, 1'b0);
    step(1);
    I_clear = 1'b0;
    chk("err_left", O_error, 1'b0);
    #1;
    chk("run_rd_en", bus.O_fifo_rd_en, 1'b1);
    step(1);
    chk("err_data_valid", bus.O_ev_valid, 1'b1);
    chk("err_data_time", bus.O_ev_time, 32'd5);
    chk("err_data_data", bus.O_ev_data, 8'h5A);
    step(1);
    chk("err_drain", bus.O_ev_valid, 1'b0);

`ifdef SNIFF_DECODER_SEQ_EN
    // sequence numbers skip TIME entries
    do_clear();
    push(ent(2'd0, 3'd1, 8'h01, 5'h00));
    push(ent(2'd0, 3'd1, 8'h02, 5'h00));
    push(ent(2'd0, 3'd1, 8'h03, 5'h00));
    push(tent(16'h0010));
    push(ent(2'd1, 3'd2, 8'h00, 5'h03));
    step(1);
    chk("seq0", bus.O_ev_seq, 16'd0);
    step(1);
    chk("seq1", bus.O_ev_seq, 16'd1);
    step(1);
    chk("seq2", bus.O_ev_seq, 16'd2);
    chk("seq2_time", bus.O_ev_time, 32'd3);
    step(1);
    chk("seq_time_noev", bus.O_ev_valid, 1'b0);
    step(1);
    chk("seq3", bus.O_ev_seq, 16'd3);
    chk("seq3_time", bus.O_ev_time, 32'h15);
    chk("seq3_isdata", bus.O_ev_is_data, 1'b0);
    step(1);
`endif

    // asynchronous reset mid-stream
    bus.I_ev_ready = 1'b0;
    push(ent(2'd0, 3'd7, 8'h99, 5'h1F));
    push(ent(2'd0, 3'd7, 8'h98, 5'h1F));
    step(1);
    chk("mid_valid", bus.O_ev_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", bus.O_ev_valid, 1'b0);
    chk("arst_time", bus.O_ev_time, 32'h0);
    chk("arst_data", bus.O_ev_data, 8'h00);
    chk("arst_stat", bus.O_ev_stat, 5'h00);
    chk("arst_isdata", bus.O_ev_is_data, 1'b0);
    chk("arst_rd_en", bus.O_fifo_rd_en, 1'b0);
    chk("arst_error", O_error, 1'b0);
    chk("arst_wrapped", O_wrapped, 1'b0);
`ifdef SNIFF_DECODER_SEQ_EN
    chk("arst_seq", bus.O_ev_seq, 16'd0);
`endif
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
